// File: rtl/uart_recv_2480.sv
// -----------------------------------------------------------------------------
// uart_recv_2480
//   Serial receiver for the 2480 link, fed directly from the board RX pin.
//   Frame format: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1),
//   no parity. The asynchronous line is synchronised, the start bit is
//   re-checked at its centre, data bits are sampled at bit centre and the
//   stop bit is validated before the byte is presented.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   UART_BPS  baud rate; BPS_CNT = CLK_FREQ/UART_BPS must be >= 16
//
// Ports
//   sys_clk    in   1  system clock, all logic on posedge
//   sys_rst_n  in   1  asynchronous active-low reset
//   uart_rxd   in   1  serial line, asynchronous, idles high
//   rx_busy    out  1  high from start-edge detect until return to IDLE
//   rx_data    out  8  last good byte, updates only together with rx_done
//   rx_done    out  1  one-cycle pulse: frame received with stop bit = 1
//   frame_err  out  1  one-cycle pulse: stop bit sampled 0
//
// Build option
//   UART_RX_MAJORITY_EN : when defined, each sample point uses a 2-of-3
//   majority over the samples taken at T-2, T-1 and T, so a single-cycle
//   glitch at a sample point is rejected. Decision timing is unchanged.
// -----------------------------------------------------------------------------
module uart_recv_2480 #(
  parameter int CLK_FREQ = 49152000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       rx_busy,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BIT_END  = 16'(BPS_CNT - 1);
  localparam logic [15:0] HALF_END = 16'(BPS_CNT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic        rxd_s0_r;
  logic        rxd_s1_r;
  logic        rxd_d_r;
  logic        fall_s;
  logic        sample_pt_s;
  logic        sample_s;
  state_t      state_r;
  logic [15:0] clk_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;

  // Two-flop synchroniser plus one delay stage for falling-edge detection;
  // resets to the idle (high) level so reset release never looks like a start.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_s0_r <= 1'b1;
      rxd_s1_r <= 1'b1;
      rxd_d_r  <= 1'b1;
    end else begin
      rxd_s0_r <= uart_rxd;
      rxd_s1_r <= rxd_s0_r;
      rxd_d_r  <= rxd_s1_r;
    end
  end

  assign fall_s = rxd_d_r & ~rxd_s1_r;

  // Sample-point decode: half a bit into START, a full bit in DATA/STOP.
  always_comb begin
    sample_pt_s = 1'b0;
    case (state_r)
      START:   sample_pt_s = (clk_cnt_r == HALF_END);
      DATA:    sample_pt_s = (clk_cnt_r == BIT_END);
      STOP:    sample_pt_s = (clk_cnt_r == BIT_END);
      default: sample_pt_s = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  // Running history of the two previous synchronised samples; because
  // clk_cnt advances every cycle these are the samples at T-1 and T-2.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rxd_s1_r};
    end
  end

  assign sample_s = maj3(hist_r[1], hist_r[0], rxd_s1_r);
`else
  assign sample_s = rxd_s1_r;
`endif

  // Receive FSM; all outputs are registered here. Counters are cleared on
  // every state change so each state measures time from its own entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= IDLE;
      clk_cnt_r <= 16'd0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      rx_data   <= 8'h00;
      rx_busy   <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          clk_cnt_r <= 16'd0;
          bit_cnt_r <= 3'd0;
          // only a 1->0 edge starts a frame; a held-low line does not
          if (fall_s) begin
            state_r <= START;
            rx_busy <= 1'b1;
          end else begin
            rx_busy <= 1'b0;
          end
        end
        START: begin
          if (sample_pt_s) begin
            clk_cnt_r <= 16'd0;
            if (!sample_s) begin
              // start bit confirmed; counter now aligned to bit centres
              state_r <= DATA;
            end else begin
              // noise pulse: drop silently
              state_r <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (sample_pt_s) begin
            clk_cnt_r <= 16'd0;
            shift_r   <= {sample_s, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
              state_r   <= STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        STOP: begin
          if (sample_pt_s) begin
            // return to IDLE at stop-bit centre so a back-to-back start
            // edge half a bit later is still seen
            clk_cnt_r <= 16'd0;
            state_r   <= IDLE;
            rx_busy   <= 1'b0;
            if (sample_s) begin
              rx_data <= shift_r;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          clk_cnt_r <= 16'd0;
          bit_cnt_r <= 3'd0;
          rx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv_2480.sv
// -----------------------------------------------------------------------------
// tb_uart_recv_2480
//   Directed bench for uart_recv_2480 with a scaled-down bit period
//   (BPS_CNT = 32) so whole frames stay short. Frames are driven onto
//   uart_rxd as 10-bit words sent LSB first ({stop, data, start}).
// -----------------------------------------------------------------------------
module tb_uart_recv_2480;

  localparam int CLK_FREQ = 320;
  localparam int UART_BPS = 10;
  localparam int BPS      = 32;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rxd  = 1'b1;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;

  uart_recv_2480 #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .uart_rxd (uart_rxd),
    .rx_busy  (rx_busy),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cycle counter and strobe monitor
  int         cyc       = 0;
  int         done_cnt  = 0;
  int         err_cnt   = 0;
  int         both_cnt  = 0;
  int         done_cyc  = 0;
  int         start_cyc = 0;
  logic [7:0] data_hist [0:15];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (rx_done) begin
      if (done_cnt < 16) data_hist[done_cnt] <= rx_data;
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (rx_done && frame_err) both_cnt <= both_cnt + 1;
  end

  // Drive the first nbits of a frame word; gbit selects a bit that gets a
  // one-cycle inverted glitch exactly at its centre sample (-1 = none).
  task automatic send_bits(input logic [9:0] frame, input int nbits, input int gbit);
    for (int i = 0; i < nbits; i++) begin
      uart_rxd = frame[i];
      if (i == 0) start_cyc = cyc;
      for (int c = 0; c < BPS; c++) begin
        if (i == gbit && c == BPS/2)          uart_rxd = ~frame[i];
        else if (i == gbit && c == BPS/2 + 1) uart_rxd = frame[i];
        @(negedge sys_clk);
      end
    end
  endtask

  int d0;
  int e0;
  int lat;

  initial begin
    // reset state
    repeat (3) @(negedge sys_clk);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_rx_done", rx_done, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_rx_busy", rx_busy, 1'b0);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    // 0xA5 good frame
    d0 = done_cnt; e0 = err_cnt;
    send_bits({1'b1, 8'hA5, 1'b0}, 10, -1);
    repeat (2) @(negedge sys_clk);
    check_eq("a5_done_cnt", done_cnt - d0, 1);
    check_eq("a5_data_at_done", data_hist[d0], 8'hA5);
    check_eq("a5_rx_data", rx_data, 8'hA5);
    check_eq("a5_err_cnt", err_cnt - e0, 0);
    check_eq("a5_busy_low", rx_busy, 1'b0);
    lat = done_cyc - start_cyc;
    check_eq("a5_latency_window", (lat >= (BPS*19)/2 + 3) && (lat <= (BPS*19)/2 + 5), 1'b1);

    // 0x55 with stop bit 0: framing error, rx_data keeps 0xA5
    d0 = done_cnt; e0 = err_cnt;
    send_bits({1'b0, 8'h55, 1'b0}, 10, -1);
    uart_rxd = 1'b1;
    repeat (BPS) @(negedge sys_clk);
    check_eq("ferr_err_cnt", err_cnt - e0, 1);
    check_eq("ferr_done_cnt", done_cnt - d0, 0);
    check_eq("ferr_rx_data", rx_data, 8'hA5);
    check_eq("ferr_busy_low", rx_busy, 1'b0);

    // transmitter-style word 10'h278 carries 0x3C
    d0 = done_cnt;
    send_bits(10'h278, 10, -1);
    repeat (2) @(negedge sys_clk);
    check_eq("lb_done_cnt", done_cnt - d0, 1);
    check_eq("lb_rx_data", rx_data, 8'h3C);

    // short low pulse: false start rejected
    d0 = done_cnt; e0 = err_cnt;
    uart_rxd = 1'b0;
    repeat (5) @(negedge sys_clk);
    check_eq("fs_busy_high", rx_busy, 1'b1);
    uart_rxd = 1'b1;
    repeat (2*BPS) @(negedge sys_clk);
    check_eq("fs_busy_low", rx_busy, 1'b0);
    check_eq("fs_done_cnt", done_cnt - d0, 0);
    check_eq("fs_err_cnt", err_cnt - e0, 0);
    check_eq("fs_rx_data", rx_data, 8'h3C);

    // back-to-back 0x00 then 0xFF with no idle gap
    d0 = done_cnt; e0 = err_cnt;
    send_bits({1'b1, 8'h00, 1'b0}, 10, -1);
    send_bits({1'b1, 8'hFF, 1'b0}, 10, -1);
    repeat (2) @(negedge sys_clk);
    check_eq("b2b_done_cnt", done_cnt - d0, 2);
    check_eq("b2b_first", data_hist[d0], 8'h00);
    check_eq("b2b_second", data_hist[d0 + 1], 8'hFF);
    check_eq("b2b_err_cnt", err_cnt - e0, 0);

    // reset during bit 4 of 0x81, then 0x42
    d0 = done_cnt; e0 = err_cnt;
    send_bits({1'b1, 8'h81, 1'b0}, 5, -1);
    uart_rxd = 1'b0;
    repeat (10) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("mrst_rx_data", rx_data, 8'h00);
    check_eq("mrst_busy", rx_busy, 1'b0);
    check_eq("mrst_done", rx_done, 1'b0);
    uart_rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (12*BPS) @(negedge sys_clk);
    check_eq("mrst_no_done", done_cnt - d0, 0);
    check_eq("mrst_no_err", err_cnt - e0, 0);
    check_eq("mrst_rx_data_hold", rx_data, 8'h00);
    send_bits({1'b1, 8'h42, 1'b0}, 10, -1);
    repeat (2) @(negedge sys_clk);
    check_eq("post_rst_done_cnt", done_cnt - d0, 1);
    check_eq("post_rst_rx_data", rx_data, 8'h42);

`ifdef UART_RX_MAJORITY_EN
    // one-cycle high glitch at bit-3 centre of 0x00 must be voted out
    d0 = done_cnt;
    send_bits({1'b1, 8'h00, 1'b0}, 10, 4);
    repeat (2) @(negedge sys_clk);
    check_eq("maj_done_cnt", done_cnt - d0, 1);
    check_eq("maj_rx_data", rx_data, 8'h00);
`endif

    check_eq("done_err_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
